// File: rtl/step_gen_pkg.sv
// Shared types and defaults for the step/load pulse generator.
package step_gen_pkg;

    typedef enum logic [1:0] {
        IdleLo,
        WaitHi,
        IdleHi,
        WaitLo
    } deb_state_e;

    localparam int unsigned DebounceCyclesDefault = 1000000;
    localparam int unsigned AutoDivDefault        = 100000000;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_gen_debounce.sv
// Two-flop synchronizer, debounce FSM and rising-edge pulse for one push-button.
module debounce
    import step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned    CntW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    deb_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            level_dly_q;
    logic            pulse_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IdleLo;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            pulse_q     <= level_q & ~level_dly_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        unique case (state_q)
            IdleLo: begin
                if (sync2_q) begin
                    state_d = WaitHi;
                    cnt_d   = '0;
                end
            end
            WaitHi: begin
                // A single sample back at the old level aborts the change.
                if (!sync2_q) begin
                    state_d = IdleLo;
                end else if (cnt_q == CntMax) begin
                    state_d = IdleHi;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            IdleHi: begin
                if (!sync2_q) begin
                    state_d = WaitLo;
                    cnt_d   = '0;
                end
            end
            WaitLo: begin
                if (sync2_q) begin
                    state_d = IdleHi;
                end else if (cnt_q == CntMax) begin
                    state_d = IdleLo;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = IdleLo;
        endcase
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/step_gen.sv
// Step/load pulse generator: debounced buttons plus a free-running auto-step prescaler
// driving a downstream FSM's advance enable, preload reset and symbol input.
module step_gen
    import step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
    parameter int unsigned AUTO_DIV        = AutoDivDefault
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_step,
    input  logic       btn_load,
    input  logic [1:0] sw_raw,
    input  logic       auto_en,
    output logic [1:0] sw_out,
    output logic       ctrl_out,
    output logic       load_out,
    output logic [7:0] step_count
);

    localparam int unsigned      PrescW   = cnt_width(AUTO_DIV);
    localparam logic [PrescW-1:0] PrescMax = PrescW'(AUTO_DIV - 1);

    logic [1:0]        sw_s1_q, sw_s2_q;
    logic              auto_s1_q, auto_s2_q;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [7:0]        count_q, count_d;
    logic              ctrl_dly_q;
    logic              step_pulse, load_pulse, auto_pulse;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_step (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .btn_i  (btn_step),
        .pulse_o(step_pulse)
    );

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_load (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .btn_i  (btn_load),
        .pulse_o(load_pulse)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            auto_s1_q  <= 1'b0;
            auto_s2_q  <= 1'b0;
            presc_q    <= '0;
            count_q    <= '0;
            ctrl_dly_q <= 1'b0;
        end else begin
            sw_s1_q    <= sw_raw;
            sw_s2_q    <= sw_s1_q;
            auto_s1_q  <= auto_en;
            auto_s2_q  <= auto_s1_q;
            presc_q    <= presc_d;
            count_q    <= count_d;
            ctrl_dly_q <= ctrl_out;
        end
    end

    // Auto pulse is the last prescaler cycle, so a clear on load restarts a full period.
    assign auto_pulse = auto_s2_q && (presc_q == PrescMax);

    always_comb begin
        load_out = load_pulse;
        // Load wins over stepping, and back-to-back sources never merge into a 2-cycle pulse.
        ctrl_out = (step_pulse | auto_pulse) & ~load_pulse & ~ctrl_dly_q;

        presc_d = presc_q;
        if (load_pulse || !auto_s2_q || (presc_q == PrescMax)) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PrescW'(1);
        end

        count_d = count_q;
        if (load_pulse) begin
            count_d = '0;
        end else if (ctrl_out) begin
            count_d = count_q + 8'd1;
        end
    end

    assign sw_out     = sw_s2_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_step_gen.sv
// Self-checking bench for step_gen: directed vector table, hand sequences and a random run
// checked cycle-by-cycle against a behavioural model.
module tb_step_gen;

    localparam int unsigned D   = 4;
    localparam int unsigned DIV = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_step, btn_load, auto_en;
    logic [1:0] sw_raw;
    logic [1:0] sw_out;
    logic       ctrl_out, load_out;
    logic [7:0] step_count;

    always #5 clk = ~clk;

    step_gen #(
        .DEBOUNCE_CYCLES(D),
        .AUTO_DIV       (DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_step  (btn_step),
        .btn_load  (btn_load),
        .sw_raw    (sw_raw),
        .auto_en   (auto_en),
        .sw_out    (sw_out),
        .ctrl_out  (ctrl_out),
        .load_out  (load_out),
        .step_count(step_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc;
    int n_ctrl, n_load, first_ctrl;

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic       lvl;
        logic       lvl_prev;
        logic       pulse;
        logic [7:0] run;
    } deb_m_t;

    logic       q_step[$];
    logic       q_load[$];
    logic       q_auto[$];
    logic [1:0] q_sw[$];
    deb_m_t     m_step, m_load;
    int         m_presc, m_count;
    logic       m_ctrl, m_load_out;
    logic [1:0] m_sw;

    // Level flips after D+1 consecutive synced samples disagreeing with it; pulse on the
    // cycle after the level has been seen high following a low.
    function automatic deb_m_t deb_next(input deb_m_t d, input logic s);
        deb_m_t n = d;
        n.pulse    = d.lvl & ~d.lvl_prev;
        n.lvl_prev = d.lvl;
        if (s != d.lvl) begin
            n.run = d.run + 8'd1;
            if (int'(n.run) == D + 1) begin
                n.lvl = s;
                n.run = '0;
            end
        end else begin
            n.run = '0;
        end
        return n;
    endfunction

    task automatic model_reset();
        q_step = '{1'b0, 1'b0};
        q_load = '{1'b0, 1'b0};
        q_auto = '{1'b0, 1'b0};
        q_sw   = '{2'b00, 2'b00};
        m_step = '0;
        m_load = '0;
        m_presc = 0;
        m_count = 0;
        m_ctrl = 1'b0;
        m_load_out = 1'b0;
        m_sw = 2'b00;
    endtask

    task automatic model_edge();
        logic s_step, s_load, a_old, a_new, auto_p;
        q_step.push_back(btn_step);
        s_step = q_step.pop_front();
        q_load.push_back(btn_load);
        s_load = q_load.pop_front();
        q_auto.push_back(auto_en);
        a_old = q_auto.pop_front();
        a_new = q_auto[0];
        q_sw.push_back(sw_raw);
        void'(q_sw.pop_front());
        m_sw = q_sw[0];

        m_count = m_load_out ? 0 : (m_ctrl ? (m_count + 1) % 256 : m_count);
        m_presc = (m_load_out || !a_old) ? 0 : (m_presc + 1) % DIV;
        m_step  = deb_next(m_step, s_step);
        m_load  = deb_next(m_load, s_load);
        auto_p  = a_new && (m_presc == DIV - 1);
        m_load_out = m_load.pulse;
        m_ctrl  = (m_step.pulse || auto_p) && !m_load_out && !m_ctrl;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {sw_out, ctrl_out, load_out, step_count};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: sw/ctrl/load/count got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                     name, cyc, act[11:10], act[9], act[8], act[7:0],
                     exp[11:10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        cyc++;
        check_vec("model", {m_sw, m_ctrl, m_load_out, 8'(m_count)});
        if (ctrl_out) begin
            n_ctrl++;
            if (first_ctrl < 0) first_ctrl = cyc;
        end
        if (load_out) n_load++;
    endtask

    // Asserts reset mid-cycle, checks outputs clear at once, releases with the given inputs
    // applied so the first edge after release is cycle 0.
    task automatic do_reset(input logic st, input logic ld, input logic au,
                            input logic [1:0] sw);
        reset_n  = 1'b0;
        btn_step = st;
        btn_load = ld;
        auto_en  = au;
        sw_raw   = sw;
        #1;
        check_vec("reset_outputs", 12'h000);
        model_reset();
        repeat (2) tick();
        reset_n    = 1'b1;
        cyc        = -1;
        n_ctrl     = 0;
        n_load     = 0;
        first_ctrl = -1;
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++) tick();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       st;
        logic       ld;
        logic       au;
        logic [1:0] sw;
        int         hold;
        int         exp_ctrl;
        int         exp_load;
        int         exp_count;
        int         exp_first;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'b00, 20, 1, 0, 1, 7};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 2'b01, 5, 1, 0, 1, 7};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 2'b10, 4, 0, 0, 0, -1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 2'b11, 20, 0, 1, 0, -1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 2'b00, 40, 5, 0, 5, 8};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 2'b01, 39, 4, 0, 4, 8};

        reset_n  = 1'b0;
        btn_step = 1'b0;
        btn_load = 1'b0;
        auto_en  = 1'b0;
        sw_raw   = 2'b00;
        cyc = 0; n_ctrl = 0; n_load = 0; first_ctrl = -1;
        model_reset();
        @(posedge clk);
        #1;

        foreach (vecs[r]) begin
            do_reset(vecs[r].st, vecs[r].ld, vecs[r].au, vecs[r].sw);
            repeat (vecs[r].hold) tick();
            check("vec_sw_out", int'(sw_out), int'(vecs[r].sw));
            btn_step = 1'b0;
            btn_load = 1'b0;
            auto_en  = 1'b0;
            repeat (12) tick();
            check("vec_ctrl_pulses", n_ctrl, vecs[r].exp_ctrl);
            check("vec_load_pulses", n_load, vecs[r].exp_load);
            check("vec_step_count", int'(step_count), vecs[r].exp_count);
            check("vec_first_ctrl", first_ctrl, vecs[r].exp_first);
        end

        // Bouncing press: 1,1,0,0,1,1,0,0 then held; final rise sampled at cycle 8.
        do_reset(1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 8; i++) begin
            btn_step = ((i % 4) < 2);
            tick();
        end
        btn_step = 1'b1;
        repeat (14) tick();
        check("bounce_first_ctrl", first_ctrl, 15);
        check("bounce_ctrl_pulses", n_ctrl, 1);
        btn_step = 1'b0;
        repeat (10) tick();

        // Step pulse lands on the same cycle as the first auto pulse (cycle 8).
        do_reset(1'b0, 1'b0, 1'b1, 2'b00);
        tick();
        btn_step = 1'b1;
        run_until(8);
        check("coinc_ctrl_hi", int'(ctrl_out), 1);
        tick();
        check("coinc_ctrl_lo", int'(ctrl_out), 0);
        check("coinc_count", int'(step_count), 1);
        check("coinc_pulses", n_ctrl, 1);
        btn_step = 1'b0;

        // Three auto steps, then a load pulse coinciding with the fourth auto pulse.
        do_reset(1'b0, 1'b0, 1'b1, 2'b00);
        run_until(24);
        btn_load = 1'b1;
        run_until(32);
        check("load_load_out", int'(load_out), 1);
        check("load_ctrl_masked", int'(ctrl_out), 0);
        check("load_count_before", int'(step_count), 3);
        tick();
        check("load_count_cleared", int'(step_count), 0);
        btn_load = 1'b0;
        run_until(39);
        check("load_ctrl_quiet", n_ctrl, 3);
        tick();
        check("load_next_auto", int'(ctrl_out), 1);
        tick();
        check("load_count_after", int'(step_count), 1);
        auto_en = 1'b0;
        repeat (4) tick();

        // Reset asserted mid-debounce with the button still held through release.
        do_reset(1'b1, 1'b0, 1'b0, 2'b00);
        run_until(2);
        do_reset(1'b1, 1'b0, 1'b0, 2'b00);
        repeat (20) tick();
        check("rst_mid_first_ctrl", first_ctrl, 7);
        check("rst_mid_pulses", n_ctrl, 1);
        btn_step = 1'b0;

        // step_count wraps 255 -> 0 under continuous auto stepping.
        do_reset(1'b0, 1'b0, 1'b1, 2'b00);
        run_until(2049);
        check("wrap_pulses", n_ctrl, 256);
        check("wrap_count", int'(step_count), 0);
        auto_en = 1'b0;
        repeat (4) tick();

        // Random run against the model, including occasional resets.
        do_reset(1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(9) == 0)  btn_step = ~btn_step;
            if ($urandom_range(29) == 0) btn_load = ~btn_load;
            if ($urandom_range(59) == 0) auto_en  = ~auto_en;
            if ($urandom_range(4) == 0)  sw_raw   = 2'($urandom_range(3));
            if ($urandom_range(499) == 0) begin
                do_reset(btn_step, btn_load, auto_en, sw_raw);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
